hamming_decoder_pipe: RTL
=========================

# hamming_decoder_pipe

Two-stage pipelined Hamming(7,4) decoder. It accepts a received 7-bit codeword through a valid/ready handshake, computes the 3-bit syndrome, and corrects any single-bit error. It holds the corrected 4-bit data word and the syndrome in registers, which drive the display multiplexer's `bin`/`sin` inputs directly. It also keeps saturating counters of decoded words and corrected errors.

## Interface
- `CNT_W`, default 8: width of the word and error counters.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `code` is valid this cycle.
- `in_ready`  out  1  decoder can accept a word.
- `code`  in  7  received word; `code[k]` = Hamming position k+1 (`p1,p2,d1,p4,d2,d3,d4` from bit 0 up).
- `clear_counts`  in  1  one-cycle pulse that zeroes both counters.
- `bin`  out  4  held corrected data `{d4,d3,d2,d1}` = `{pos7,pos6,pos5,pos3}`.
- `sin`  out  3  held syndrome `{s4,s2,s1}`.
- `out_valid`  out  1  one-cycle pulse when `bin`/`sin` update.
- `err_flag`  out  1  held; 1 if the last decoded word had a non-zero syndrome.
- `word_count`  out  `CNT_W`  saturating count of decoded words.
- `err_count`  out  `CNT_W`  saturating count of words with a non-zero syndrome.

## Operation
- Accept: a word is taken on a rising edge where `in_valid && in_ready`.
- `in_ready`: registered. It is 0 in any cycle where `rst` was sampled high on the previous edge, and 1 otherwise. There is no backpressure; the pipeline never stalls.
- Stage 1 (edge of acceptance) registers:
  - the raw code;
  - `s1 = pos1^pos3^pos5^pos7`, `s2 = pos2^pos3^pos6^pos7`, `s4 = pos4^pos5^pos6^pos7`;
  - a stage-1 valid bit.
- Stage 2 (next edge, if the stage-1 valid bit is set):
  - corrected = code with bit `(s-1)` inverted when `s != 0`; unchanged when `s == 0`;
  - loads `bin` from the corrected data positions, `sin <= s`, `err_flag <= (s != 0)`;
  - asserts `out_valid` for exactly one cycle.
- Double-bit errors are not detected: the syndrome is treated as a single-error position, and the result is a mis-correction by design.
- `bin`, `sin` and `err_flag` hold their last value between decodes; the display stage samples them at any time.
- Counters:
  - `word_count` increments on each stage-2 completion;
  - `err_count` increments when that completion has `s != 0`;
  - both saturate at `2^CNT_W-1` and never wrap.
- `clear_counts`: if it coincides with a completion, clear wins and both counters become 0 (the completing word is not counted). It does not affect `bin`, `sin`, `err_flag` or the pipeline.
- Back-to-back words are accepted every cycle; each produces its own `out_valid` pulse, 2 cycles after acceptance, in order.

## Timing
- Reset values:
  - `bin = 0`, `sin = 0`, `err_flag = 0`, `out_valid = 0`, `word_count = 0`, `err_count = 0`;
  - stage-1 valid = 0, `in_ready = 0`.
- Latency: word accepted at edge N → `bin`/`sin`/`err_flag` updated and `out_valid = 1` after edge N+1 → `out_valid` low again after edge N+2 (unless another word follows).
- Throughput: 1 word/cycle.
- Reset mid-operation: in-flight words are discarded, with no `out_valid` for them. All outputs take their reset values on the edge where `rst` = 1. `in_ready` returns to 1 one cycle after `rst` deasserts.
- `in_valid` while `in_ready = 0` is ignored; the word is lost and not counted.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset: hold `rst` 3 cycles, then release → all outputs 0 during reset; `in_ready = 1` on the second cycle after release; `out_valid` stays 0.
- Clean word: `code = 7'h55` for one cycle → after 2 cycles `bin = 4'b1011`, `sin = 3'b000`, `err_flag = 0`, one `out_valid` pulse, `word_count = 1`, `err_count = 0`.
- Single error: `code = 7'h45` (position 5 flipped) → `bin = 4'b1011`, `sin = 3'b101`, `err_flag = 1`, `err_count = 1`. Repeat for each of positions 1..7 flipped from `7'h55` → `bin` is always `4'b1011` and `sin` equals the position number.
- Streaming: `7'h55`, `7'h45`, `7'h54` (position 1 flipped) on consecutive cycles → three consecutive `out_valid` pulses with `sin = 0, 5, 1` in order; `word_count = 3`, `err_count = 2`.
- Saturation and clear:
  - with `CNT_W = 2`, send 5 erroneous words → both counters stick at 3;
  - assert `clear_counts` on the same cycle as a completing word → both counters 0 next cycle, and `bin`/`sin` still update.
- Reset mid-flight: accept `7'h45`, assert `rst` on the next edge → no `out_valid`, `sin = 0`, `err_count = 0`.

Source files
------------

// File: rtl/hamming_decoder_pipe.sv
// Two-stage pipelined Hamming(7,4) decoder.
// Stage 1 latches the received word and its syndrome. Stage 2 corrects a
// single-bit error and updates the held data/syndrome/error outputs.
// Saturating counters track the number of decoded words and corrected errors.
// code[k] holds Hamming position k+1: {p1,p2,d1,p4,d2,d3,d4} from bit 0 upward.
module hamming_decoder_pipe #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       code,
  input  logic             clear_counts,
  output logic [3:0]       bin,
  output logic [2:0]       sin,
  output logic             out_valid,
  output logic             err_flag,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] err_count
);

  // Syndrome {s4,s2,s1}. A nonzero value is the 1-based position of the flipped bit.
  function automatic logic [2:0] calc_syndrome(input logic [6:0] c);
    logic s1;
    logic s2;
    logic s4;
    s1 = c[0] ^ c[2] ^ c[4] ^ c[6];
    s2 = c[1] ^ c[2] ^ c[5] ^ c[6];
    s4 = c[3] ^ c[4] ^ c[5] ^ c[6];
    return {s4, s2, s1};
  endfunction

  // Invert the bit named by the syndrome. A double error is mis-corrected here
  // because it cannot be told apart from a single error.
  function automatic logic [6:0] correct_code(input logic [6:0] c, input logic [2:0] s);
    logic [6:0] flip;
    flip = 7'b000_0001 << (s - 3'd1);
    return (s == 3'd0) ? c : (c ^ flip);
  endfunction

  // Data bits {d4,d3,d2,d1} sit at positions {7,6,5,3}.
  function automatic logic [3:0] extract_data(input logic [6:0] c);
    return {c[6], c[5], c[4], c[2]};
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic             in_ready_d, in_ready_q;
  logic [6:0]       code_p0_d, code_p0_q;
  logic [2:0]       syn_p0_d, syn_p0_q;
  logic             vld_p0_d, vld_p0_q;
  logic [3:0]       bin_p1_d, bin_p1_q;
  logic [2:0]       sin_p1_d, sin_p1_q;
  logic             err_p1_d, err_p1_q;
  logic             vld_p1_d, vld_p1_q;
  logic [CNT_W-1:0] word_cnt_d, word_cnt_q;
  logic [CNT_W-1:0] err_cnt_d, err_cnt_q;
  logic             accept;

  assign accept = in_valid && in_ready_q;

  // Ready drops for exactly the cycles following a reset edge; nothing stalls.
  always_comb begin
    in_ready_d = 1'b1;
  end

  // ---- stage 0 -> stage 1: capture word and syndrome on acceptance ----
  always_comb begin
    code_p0_d = code_p0_q;
    syn_p0_d  = syn_p0_q;
    vld_p0_d  = accept;
    if (accept) begin
      code_p0_d = code;
      syn_p0_d  = calc_syndrome(code);
    end
  end

  // ---- stage 1 -> stage 2: correct and update the held outputs ----
  always_comb begin
    bin_p1_d = bin_p1_q;
    sin_p1_d = sin_p1_q;
    err_p1_d = err_p1_q;
    vld_p1_d = vld_p0_q;
    if (vld_p0_q) begin
      bin_p1_d = extract_data(correct_code(code_p0_q, syn_p0_q));
      sin_p1_d = syn_p0_q;
      err_p1_d = (syn_p0_q != 3'd0);
    end
  end

  // Counters advance on each stage-2 completion; a clear pulse overrides it.
  always_comb begin
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (clear_counts) begin
      word_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (vld_p0_q) begin
      word_cnt_d = sat_inc(word_cnt_q);
      if (syn_p0_q != 3'd0) begin
        err_cnt_d = sat_inc(err_cnt_q);
      end
    end
  end

  // Control, held outputs and counters; reset discards in-flight words.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q <= 1'b0;
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      bin_p1_q   <= '0;
      sin_p1_q   <= '0;
      err_p1_q   <= 1'b0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      in_ready_q <= in_ready_d;
      vld_p0_q   <= vld_p0_d;
      vld_p1_q   <= vld_p1_d;
      bin_p1_q   <= bin_p1_d;
      sin_p1_q   <= sin_p1_d;
      err_p1_q   <= err_p1_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Stage-1 datapath registers; only meaningful while vld_p0_q is set.
  always_ff @(posedge clk) begin
    code_p0_q <= code_p0_d;
    syn_p0_q  <= syn_p0_d;
  end

  assign in_ready   = in_ready_q;
  assign bin        = bin_p1_q;
  assign sin        = sin_p1_q;
  assign err_flag   = err_p1_q;
  assign out_valid  = vld_p1_q;
  assign word_count = word_cnt_q;
  assign err_count  = err_cnt_q;

endmodule
